// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/memory/
// writeback, waits on mem_ready_i, and traps on memory timeout or illegal opcode.
module multicycle_control #(
    parameter int unsigned ALU_OP_WIDTH = 3,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned STATE_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5:0]              opcode_i,
    input  logic [5:0]              funct_i,
    input  logic                    mem_ready_i,
    output logic                    pc_write_o,
    output logic                    pc_write_eq_o,
    output logic                    pc_write_ne_o,
    output logic                    i_or_d_o,
    output logic                    mem_read_o,
    output logic                    mem_write_o,
    output logic                    ir_write_o,
    output logic [1:0]              reg_dst_o,
    output logic [1:0]              mem_to_reg_o,
    output logic                    reg_write_o,
    output logic                    alu_src_a_o,
    output logic [1:0]              alu_src_b_o,
    output logic [1:0]              pc_source_o,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic [STATE_WIDTH-1:0]  state_o,
    output logic                    error_o
);

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StFetch    = 4'd1,
        StDecode   = 4'd2,
        StMemAddr  = 4'd3,
        StMemRead  = 4'd4,
        StMemWb    = 4'd5,
        StMemWrite = 4'd6,
        StRExec    = 4'd7,
        StRWb      = 4'd8,
        StBeq      = 4'd9,
        StBne      = 4'd10,
        StIExec    = 4'd11,
        StIWb      = 4'd12,
        StJ        = 4'd13,
        StJal      = 4'd14,
        StJr       = 4'd15
    } state_e;

    localparam logic [2:0] AluAdd  = 3'b100;
    localparam logic [2:0] AluSub  = 3'b001;
    localparam logic [2:0] AluMem  = 3'b011;
    localparam logic [2:0] AluR    = 3'b111;
    localparam logic [2:0] AluOri  = 3'b101;
    localparam logic [2:0] AluLui  = 3'b110;

    localparam logic [15:0] WaitLast = 16'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic        error_q, error_d;
    logic        mem_state;
    logic        timeout;

    assign mem_state = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
    // Ready on the final allowed wait cycle still completes the access.
    assign timeout   = mem_state && !mem_ready_i && (wait_q == WaitLast);

    always_comb begin
        state_d = state_q;
        error_d = error_q;
        case (state_q)
            StIdle:     if (!error_q) state_d = StFetch;
            StFetch:    if (mem_ready_i) state_d = StDecode;
            StDecode: begin
                case (opcode_i)
                    6'h00:        state_d = (funct_i == 6'h08) ? StJr : StRExec;
                    6'h23, 6'h2b: state_d = StMemAddr;
                    6'h04:        state_d = StBeq;
                    6'h05:        state_d = StBne;
                    6'h08, 6'h0d, 6'h0f: state_d = StIExec;
                    6'h02:        state_d = StJ;
                    6'h03:        state_d = StJal;
                    default: begin
                        state_d = StIdle;
                        error_d = 1'b1;
                    end
                endcase
            end
            StMemAddr:  state_d = (opcode_i == 6'h23) ? StMemRead : StMemWrite;
            StMemRead:  if (mem_ready_i) state_d = StMemWb;
            StMemWrite: if (mem_ready_i) state_d = StFetch;
            StRExec:    state_d = StRWb;
            StIExec:    state_d = StIWb;
            StMemWb, StRWb, StIWb, StBeq, StBne, StJ, StJal, StJr: state_d = StFetch;
            default:    state_d = StIdle;
        endcase
        if (timeout) begin
            state_d = StIdle;
            error_d = 1'b1;
        end
    end

    always_comb begin
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_state && !mem_ready_i) begin
            wait_d = wait_q + 16'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            wait_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        pc_write_o    = 1'b0;
        pc_write_eq_o = 1'b0;
        pc_write_ne_o = 1'b0;
        i_or_d_o      = 1'b0;
        mem_read_o    = 1'b0;
        mem_write_o   = 1'b0;
        ir_write_o    = 1'b0;
        reg_dst_o     = 2'b00;
        mem_to_reg_o  = 2'b00;
        reg_write_o   = 1'b0;
        alu_src_a_o   = 1'b0;
        alu_src_b_o   = 2'b00;
        pc_source_o   = 2'b00;
        alu_op_o      = '0;
        case (state_q)
            StFetch: begin
                mem_read_o    = 1'b1;
                alu_src_b_o   = 2'b01;
                alu_op_o[2:0] = AluAdd;
                ir_write_o    = mem_ready_i;
                pc_write_o    = mem_ready_i;
            end
            StDecode: begin
                alu_src_b_o   = 2'b11;
                alu_op_o[2:0] = AluAdd;
            end
            StMemAddr: begin
                alu_src_a_o   = 1'b1;
                alu_src_b_o   = 2'b10;
                alu_op_o[2:0] = AluMem;
            end
            StMemRead: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            StMemWb: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'b01;
            end
            StMemWrite: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
            end
            StRExec: begin
                alu_src_a_o   = 1'b1;
                alu_op_o[2:0] = AluR;
            end
            StRWb: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 2'b01;
            end
            StBeq, StBne: begin
                alu_src_a_o   = 1'b1;
                alu_op_o[2:0] = AluSub;
                pc_source_o   = 2'b01;
                pc_write_eq_o = (state_q == StBeq);
                pc_write_ne_o = (state_q == StBne);
            end
            StIExec: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                case (opcode_i)
                    6'h0d:   alu_op_o[2:0] = AluOri;
                    6'h0f:   alu_op_o[2:0] = AluLui;
                    default: alu_op_o[2:0] = AluAdd;
                endcase
            end
            StIWb: reg_write_o = 1'b1;
            StJ: begin
                pc_write_o  = 1'b1;
                pc_source_o = 2'b10;
            end
            StJal: begin
                pc_write_o   = 1'b1;
                pc_source_o  = 2'b10;
                reg_write_o  = 1'b1;
                reg_dst_o    = 2'b10;
                mem_to_reg_o = 2'b10;
            end
            StJr: begin
                pc_write_o  = 1'b1;
                pc_source_o = 2'b11;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_o      = '0;
        state_o[3:0] = state_q;
    end

    assign error_o = error_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench: main instance with default timeout, second instance with MEM_TIMEOUT = 3.
module tb_multicycle_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [5:0] op, fn;
    logic       r, rdy, r2, rdy2;

    logic       pcw, pweq, pwne, iord, mr, mw, irw, rw, asa, err;
    logic [1:0] rdst, m2r, asb, psrc;
    logic [2:0] aop;
    logic [3:0] st;

    logic       pcw2, pweq2, pwne2, iord2, mr2, mw2, irw2, rw2, asa2, err2;
    logic [1:0] rdst2, m2r2, asb2, psrc2;
    logic [2:0] aop2;
    logic [3:0] st2;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_control u_dut (
        .clk(clk), .reset(r), .opcode_i(op), .funct_i(fn), .mem_ready_i(rdy),
        .pc_write_o(pcw), .pc_write_eq_o(pweq), .pc_write_ne_o(pwne), .i_or_d_o(iord),
        .mem_read_o(mr), .mem_write_o(mw), .ir_write_o(irw), .reg_dst_o(rdst),
        .mem_to_reg_o(m2r), .reg_write_o(rw), .alu_src_a_o(asa), .alu_src_b_o(asb),
        .pc_source_o(psrc), .alu_op_o(aop), .state_o(st), .error_o(err)
    );

    multicycle_control #(.MEM_TIMEOUT(3)) u_to (
        .clk(clk), .reset(r2), .opcode_i(op), .funct_i(fn), .mem_ready_i(rdy2),
        .pc_write_o(pcw2), .pc_write_eq_o(pweq2), .pc_write_ne_o(pwne2), .i_or_d_o(iord2),
        .mem_read_o(mr2), .mem_write_o(mw2), .ir_write_o(irw2), .reg_dst_o(rdst2),
        .mem_to_reg_o(m2r2), .reg_write_o(rw2), .alu_src_a_o(asa2), .alu_src_b_o(asb2),
        .pc_source_o(psrc2), .alu_op_o(aop2), .state_o(st2), .error_o(err2)
    );

    // Every non-debug output of each instance, concatenated.
    wire [21:0] all1 = {pcw, pweq, pwne, iord, mr, mw, irw, rw, asa, rdst, m2r, asb, psrc, aop, err};
    wire [21:0] all2 = {pcw2, pweq2, pwne2, iord2, mr2, mw2, irw2, rw2, asa2, rdst2, m2r2, asb2,
                        psrc2, aop2, err2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        r = 1'b0; rdy = 1'b0; r2 = 1'b0; rdy2 = 1'b0; op = 6'h00; fn = 6'h00;
        #3;
        chk("reset_state", 32'(st), 32'd0);
        chk("reset_outputs", 32'(all1), 32'd0);
        step();
        r = 1'b1;
        step();
        chk("fetch_state", 32'(st), 32'd1);
        chk("fetch_mem_read", 32'(mr), 32'd1);
        chk("fetch_irw_not_ready", 32'(irw), 32'd0);
        rdy = 1'b1;
        #1;
        chk("fetch_irw_ready", 32'({irw, pcw, asb, aop}), 32'b1_1_01_100);

        // R-type add: 1,2,7,8,1
        op = 6'h00; fn = 6'h20;
        step(); chk("r_decode", 32'({st, asb, aop}), 32'b0010_11_100);
        step(); chk("r_exec", 32'({st, aop, rw, asa}), 32'b0111_111_0_1);
        step(); chk("r_wb", 32'({st, rw, rdst, m2r}), 32'b1000_1_01_00);
        step(); chk("r_back_fetch", 32'(st), 32'd1);

        // LW with 4 wait cycles in MEM_READ
        op = 6'h23;
        step(); chk("lw_decode", 32'(st), 32'd2);
        step(); chk("lw_addr", 32'({st, asa, asb, aop}), 32'b0011_1_10_011);
        rdy = 1'b0;
        step(); chk("lw_read_c1", 32'({st, mr, iord}), 32'b0100_1_1);
        step(); chk("lw_read_c2", 32'(st), 32'd4);
        step(); chk("lw_read_c3", 32'(st), 32'd4);
        step(); chk("lw_read_c4", 32'(st), 32'd4);
        step(); chk("lw_read_c5", 32'({st, mr, iord}), 32'b0100_1_1);
        rdy = 1'b1;
        step(); chk("lw_wb", 32'({st, rw, rdst, m2r}), 32'b0101_1_00_01);
        step(); chk("lw_back_fetch", 32'(st), 32'd1);

        // SW
        op = 6'h2b;
        step(); step(); chk("sw_addr", 32'(st), 32'd3);
        step(); chk("sw_write", 32'({st, mw, iord, mr}), 32'b0110_1_1_0);
        step(); chk("sw_back_fetch", 32'(st), 32'd1);

        // JAL
        op = 6'h03;
        step(); step();
        chk("jal", 32'({st, pcw, psrc, rw, rdst, m2r}), 32'b1110_1_10_1_10_10);
        step(); chk("jal_back_fetch", 32'(st), 32'd1);

        // JR
        op = 6'h00; fn = 6'h08;
        step(); step(); chk("jr", 32'({st, pcw, psrc}), 32'b1111_1_11);
        step();

        // BNE and BEQ
        op = 6'h05;
        step(); step();
        chk("bne", 32'({st, pwne, pweq, pcw, psrc, aop, asa, asb}), 32'b1010_1_0_0_01_001_1_00);
        step();
        op = 6'h04;
        step(); step(); chk("beq", 32'({st, pweq, pwne}), 32'b1001_1_0);
        step();

        // LUI and ORI go through I_EXEC
        op = 6'h0f;
        step(); step(); chk("lui_exec", 32'({st, aop, asa, asb}), 32'b1011_110_1_10);
        step(); chk("lui_wb", 32'({st, rw, rdst, m2r}), 32'b1100_1_00_00);
        step();
        op = 6'h0d;
        step(); step(); chk("ori_exec", 32'({st, aop}), 32'b1011_101);
        step(); step();
        op = 6'h08;
        step(); step(); chk("addi_exec", 32'({st, aop}), 32'b1011_100);
        step(); step(); chk("addi_back_fetch", 32'(st), 32'd1);

        // Illegal opcode traps after DECODE and stays trapped
        op = 6'h3f;
        step(); chk("ill_decode", 32'(st), 32'd2);
        step(); chk("ill_error", 32'(all1), 32'd1);
        chk("ill_state", 32'(st), 32'd0);
        step(); step(); chk("ill_sticky", 32'({st, all1}), 32'd1);

        // Reset clears the trap; then abort mid-MEM_READ
        r = 1'b0; #1;
        chk("rst_clears_err", 32'(err), 32'd0);
        step(); r = 1'b1;
        op = 6'h23;
        step(); step(); step(); step(); chk("abort_in_read", 32'({st, mr}), 32'b0100_1);
        r = 1'b0; #1;
        chk("abort_async_state", 32'(st), 32'd0);
        chk("abort_async_outputs", 32'(all1), 32'd0);
        step(); step(); step();
        chk("abort_held", 32'({st, all1}), 32'd0);
        r = 1'b1;
        step(); chk("abort_release", 32'({st, mr}), 32'b0001_1);

        // Timeout instance: 3 wait cycles in FETCH -> error
        rdy2 = 1'b0;
        r2 = 1'b1;
        step(); chk("to_fetch", 32'(st2), 32'd1);
        step(); chk("to_wait2", 32'(st2), 32'd1);
        step(); chk("to_wait3", 32'({st2, err2}), 32'b0001_0);
        step(); chk("to_error", 32'({st2, all2}), 32'd1);
        step(); step(); chk("to_sticky", 32'({st2, all2}), 32'd1);
        // Ready on the 3rd wait cycle wins
        r2 = 1'b0; #1;
        chk("to_rst", 32'(all2), 32'd0);
        step(); r2 = 1'b1;
        step(); step(); step();
        rdy2 = 1'b1; #1;
        chk("to_ready_last", 32'({st2, irw2}), 32'b0001_1);
        step(); chk("to_decode", 32'({st2, err2}), 32'b0010_0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM control unit for the multi-cycle MIPS datapath, replacing single-cycle opcode decode.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and waits on memory with a ready handshake.
- Adds a timeout error trap and an illegal-opcode trap.
- Sits between the instruction register (opcode_i, funct_i) and the datapath muxes, PC, register file and memory.

Parameters:
- ALU_OP_WIDTH, 3, width of alu_op_o; encodings below are zero-extended when wider.
- MEM_TIMEOUT, 255, max cycles spent waiting on mem_ready_i in one memory state before ERROR; 1..65535.
- STATE_WIDTH, 4, width of state_o; must be >= 4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- opcode_i  input  6  instruction[31:26] from IR
- funct_i  input  6  instruction[5:0] from IR
- mem_ready_i  input  1  memory completes the current access this cycle
- pc_write_o  output  1  unconditional PC load
- pc_write_eq_o  output  1  PC load if ALU zero
- pc_write_ne_o  output  1  PC load if ALU not zero
- i_or_d_o  output  1  memory address: 0 = PC, 1 = ALUOut
- mem_read_o  output  1  memory read strobe
- mem_write_o  output  1  memory write strobe
- ir_write_o  output  1  IR load
- reg_dst_o  output  2  00 = rt, 01 = rd, 10 = $31
- mem_to_reg_o  output  2  00 = ALUOut, 01 = MDR, 10 = PC
- reg_write_o  output  1  register-file write
- alu_src_a_o  output  1  0 = PC, 1 = A
- alu_src_b_o  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- pc_source_o  output  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = A (JR)
- alu_op_o  output  ALU_OP_WIDTH  ALU command
- state_o  output  STATE_WIDTH  current state code, for debug
- error_o  output  1  sticky: timeout or illegal opcode

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE (0), wait counter = 0, error_o = 0.
  - Every output is 0.
  - Reset asserted mid-instruction aborts immediately; no strobe may remain high.
- Outputs are decoded combinationally from the state register only (Moore). Any output not listed for a state is 0.
- ALU op codes:
  - ADD = 100: PC increment, branch target, ADDI.
  - SUB = 001: branch compare.
  - MEM = 011: LW/SW address.
  - R-type = 111, ORI = 101, LUI = 110.
- States, codes, outputs and next state:
  - IDLE (0): all outputs 0. Next is always FETCH.
  - FETCH (1): mem_read, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = ADD.
    - ir_write and pc_write are asserted only while mem_ready_i = 1; they are the only Mealy-qualified outputs.
    - Leaves to DECODE when mem_ready_i = 1.
  - DECODE (2): alu_src_a = 0, alu_src_b = 11, alu_op = ADD (precomputes branch target).
    - Opcode 00 with funct 08 -> JR.
    - Opcode 00 otherwise -> R_EXEC.
    - 23 or 2b -> MEM_ADDR.
    - 04 -> BEQ; 05 -> BNE.
    - 08, 0d or 0f -> I_EXEC.
    - 02 -> J; 03 -> JAL.
    - Any other opcode -> ERROR.
  - MEM_ADDR (3): alu_src_a = 1, alu_src_b = 10, alu_op = MEM. Opcode 23 -> MEM_READ, else MEM_WRITE.
  - MEM_READ (4): mem_read, i_or_d = 1. Leaves to MEM_WB on mem_ready_i.
  - MEM_WB (5): reg_write, reg_dst = 00, mem_to_reg = 01. Next FETCH.
  - MEM_WRITE (6): mem_write, i_or_d = 1. Leaves to FETCH on mem_ready_i.
  - R_EXEC (7): alu_src_a = 1, alu_src_b = 00, alu_op = 111. Next R_WB.
  - R_WB (8): reg_write, reg_dst = 01, mem_to_reg = 00. Next FETCH.
  - BEQ (9) / BNE (10): alu_src_a = 1, alu_src_b = 00, alu_op = SUB, pc_source = 01, plus pc_write_eq or pc_write_ne respectively. Next FETCH.
  - I_EXEC (11): alu_src_a = 1, alu_src_b = 10, alu_op = ADD/ORI/LUI per opcode. Next I_WB.
  - I_WB (12): reg_write, reg_dst = 00, mem_to_reg = 00. Next FETCH.
  - J (13): pc_write, pc_source = 10. Next FETCH.
  - JAL (14): pc_write, pc_source = 10, reg_write, reg_dst = 10, mem_to_reg = 10 (PC already incremented). Next FETCH.
  - JR (15, funct 08): pc_write, pc_source = 11. Next FETCH.
  - ERROR (shares IDLE code 0 with error_o = 1): all outputs 0 except error_o. Held until reset.
- Opcode 0x0f (LUI) must be handled by I_EXEC; it must not fall to ERROR.
- Wait counter:
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE.
  - Increments each cycle in one of those states with mem_ready_i = 0.
  - When the counter reaches MEM_TIMEOUT with mem_ready_i still 0 -> ERROR.
  - mem_ready_i = 1 on the same cycle the counter hits MEM_TIMEOUT: ready wins and the access completes.
- mem_ready_i is ignored outside memory states.
- Latency with mem_ready_i tied 1:
  - R-type, ADDI, ORI, LUI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ, BNE, J, JAL, JR: 3 cycles.

Test Plan:
- Reset low for 3 cycles mid-MEM_READ -> all outputs 0 and state_o = 0 asynchronously; first edge after release gives state_o = 1, mem_read_o = 1.
- mem_ready_i = 1, opcode 00, funct 20 -> state sequence 1, 2, 7, 8, 1. alu_op_o = 111 in state 7. reg_write_o = 1 and reg_dst_o = 01 only in state 8.
- LW (23) with mem_ready_i low for 4 cycles in MEM_READ -> stays in state 4 for 5 cycles with mem_read_o = 1 and i_or_d_o = 1, then state 5 with mem_to_reg_o = 01.
- MEM_TIMEOUT = 3, mem_ready_i held 0 in FETCH -> after 3 wait cycles error_o = 1 and all strobes 0, sticky until reset. Repeat with ready rising on the 3rd cycle -> DECODE reached and error_o stays 0.
- JAL (03) -> state 14 with pc_write_o = 1, pc_source_o = 10, reg_dst_o = 10, mem_to_reg_o = 10. Opcode 00/funct 08 -> state 15 with pc_source_o = 11.
- BNE (05) -> state 10 with pc_write_ne_o = 1 and pc_write_eq_o = 0. Opcode 3f -> error_o = 1 after DECODE.
